fp_sign_arbiter: RTL and testbench

FP_SIGN_ARBITER -- requirements
Module: fp_sign_arbiter

---
 rtl/fp_sign_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fp_sign_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sign_arbiter.sv
// Round-robin arbiter feeding a two-stage pipeline that rewrites the sign bit of
// half- or single-precision operands (pass / abs / neg / nabs).
module fp_sign_arbiter #(
   parameter int    BITS      = 16,
   parameter string PRECISION = "HALF",
   parameter int    NREQ      = 4,
   localparam int   IDW       = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [BITS*NREQ-1:0] req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BITS-1:0]      out_data,
   output logic [IDW-1:0]       out_id,
   output logic [1:0]           in_flight
);

   localparam int SIGN = BITS - 1;

   if (!((PRECISION == "HALF" && BITS == 16) || (PRECISION == "SINGLE" && BITS == 32))) begin : gBadFormat
      $error("fp_sign_arbiter: PRECISION must be HALF with BITS=16 or SINGLE with BITS=32");
   end
   if (NREQ < 2 || NREQ > 8) begin : gBadNreq
      $error("fp_sign_arbiter: NREQ must be in 2..8");
   end

   logic             s1Valid_q, s1Valid_d;
   logic [BITS-1:0]  s1Data_q, s1Data_d;
   logic [1:0]       s1Op_q, s1Op_d;
   logic [IDW-1:0]   s1Id_q, s1Id_d;
   logic             s2Valid_q, s2Valid_d;
   logic [BITS-1:0]  s2Data_q, s2Data_d;
   logic [IDW-1:0]   s2Id_q, s2Id_d;
   logic [IDW-1:0]   lastGrant_q, lastGrant_d;
   logic [1:0]       inFlight_q, inFlight_d;

   logic [BITS-1:0]  reqDataArr [NREQ];
   logic [1:0]       reqOpArr [NREQ];
   logic             winnerValid;
   logic [IDW-1:0]   winnerId;
   logic             outFire;
   logic             advance;
   logic             s1Accept;
   logic             transfer;

   for (genvar g = 0; g < NREQ; g++) begin : gUnpack
      assign reqDataArr[g] = req_data[BITS*g +: BITS];
      assign reqOpArr[g]   = req_op[2*g +: 2];
   end

   // Only the sign bit is touched, so NaN/Inf/zero/subnormal need no special handling.
   function automatic logic [BITS-1:0] applyOp(input logic [BITS-1:0] d, input logic [1:0] op);
      logic [BITS-1:0] r;
      r = d;
      case (op)
         2'b01:   r[SIGN] = 1'b0;
         2'b10:   r[SIGN] = ~d[SIGN];
         2'b11:   r[SIGN] = 1'b1;
         default: r = d;
      endcase
      return r;
   endfunction

   assign outFire  = s2Valid_q & out_ready;
   assign advance  = s1Valid_q & (~s2Valid_q | outFire);
   assign s1Accept = ~s1Valid_q | advance;
   assign transfer = |(req_valid & req_ready);

   // Search starts one past the last grant and wraps, giving round-robin fairness.
   always_comb begin
      int sum;
      logic [IDW-1:0] cand;
      winnerValid = 1'b0;
      winnerId    = '0;
      sum         = 0;
      cand        = '0;
      for (int off = 1; off <= NREQ; off++) begin
         sum = int'(lastGrant_q) + off;
         if (sum >= NREQ) begin
            sum = sum - NREQ;
         end
         cand = IDW'(sum);
         if (!winnerValid && req_valid[cand]) begin
            winnerValid = 1'b1;
            winnerId    = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && winnerValid && s1Accept) begin
         req_ready[winnerId] = 1'b1;
      end
   end

   always_comb begin
      s1Valid_d   = s1Valid_q;
      s1Data_d    = s1Data_q;
      s1Op_d      = s1Op_q;
      s1Id_d      = s1Id_q;
      s2Valid_d   = s2Valid_q;
      s2Data_d    = s2Data_q;
      s2Id_d      = s2Id_q;
      lastGrant_d = lastGrant_q;
      inFlight_d  = inFlight_q;

      if (advance) begin
         s2Valid_d = 1'b1;
         s2Data_d  = applyOp(s1Data_q, s1Op_q);
         s2Id_d    = s1Id_q;
      end else if (outFire) begin
         s2Valid_d = 1'b0;
      end

      if (transfer) begin
         s1Valid_d   = 1'b1;
         s1Data_d    = reqDataArr[winnerId];
         s1Op_d      = reqOpArr[winnerId];
         s1Id_d      = winnerId;
         lastGrant_d = winnerId;
      end else if (advance) begin
         s1Valid_d = 1'b0;
      end

      case ({transfer, outFire})
         2'b10:   inFlight_d = inFlight_q + 2'd1;
         2'b01:   inFlight_d = inFlight_q - 2'd1;
         default: inFlight_d = inFlight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid_q   <= 1'b0;
         s1Data_q    <= '0;
         s1Op_q      <= '0;
         s1Id_q      <= '0;
         s2Valid_q   <= 1'b0;
         s2Data_q    <= '0;
         s2Id_q      <= '0;
         lastGrant_q <= IDW'(NREQ - 1);
         inFlight_q  <= '0;
      end else begin
         s1Valid_q   <= s1Valid_d;
         s1Data_q    <= s1Data_d;
         s1Op_q      <= s1Op_d;
         s1Id_q      <= s1Id_d;
         s2Valid_q   <= s2Valid_d;
         s2Data_q    <= s2Data_d;
         s2Id_q      <= s2Id_d;
         lastGrant_q <= lastGrant_d;
         inFlight_q  <= inFlight_d;
      end
   end

   assign out_valid = s2Valid_q;
   assign out_data  = s2Data_q;
   assign out_id    = s2Id_q;
   assign in_flight = inFlight_q;

endmodule

// File: tb/tb_fp_sign_arbiter.sv
// Bench for fp_sign_arbiter: a queue-based model checks the HALF instance every cycle,
// directed literal checks pin the model, and a SINGLE instance gets literal checks.
module tb_fp_sign_arbiter;

   localparam int NREQ = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  reqValid;
   logic [7:0]  reqOp;
   logic [63:0] reqData;
   logic [3:0]  reqReady;
   logic        outValid;
   logic        outReady;
   logic [15:0] outData;
   logic [1:0]  outId;
   logic [1:0]  inFlight;

   logic [1:0]  sValid;
   logic [3:0]  sOp;
   logic [63:0] sData;
   logic [1:0]  sReady;
   logic        sOutValid;
   logic        sOutReady;
   logic [31:0] sOutData;
   logic [0:0]  sOutId;
   logic [1:0]  sInFlight;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] data;
      int          id;
      int          age;
   } entry_t;

   entry_t mQueue[$];
   int     mLast  = NREQ - 1;
   bit     mArmed = 1'b0;

   fp_sign_arbiter #(.BITS(16), .PRECISION("HALF"), .NREQ(NREQ)) dutHalf (
      .clk(clk), .rst(rst),
      .req_valid(reqValid), .req_op(reqOp), .req_data(reqData), .req_ready(reqReady),
      .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_id(outId),
      .in_flight(inFlight)
   );

   fp_sign_arbiter #(.BITS(32), .PRECISION("SINGLE"), .NREQ(2)) dutSingle (
      .clk(clk), .rst(rst),
      .req_valid(sValid), .req_op(sOp), .req_data(sData), .req_ready(sReady),
      .out_valid(sOutValid), .out_ready(sOutReady), .out_data(sOutData), .out_id(sOutId),
      .in_flight(sInFlight)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [7:0] op, input logic [63:0] d,
                                input logic rdy);
      reqValid = v;
      reqOp    = op;
      reqData  = d;
      outReady = rdy;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] modelOp(input logic [15:0] d, input logic [1:0] op);
      case (op)
         2'd1:    return d & 16'h7FFF;
         2'd2:    return d ^ 16'h8000;
         2'd3:    return d | 16'h8000;
         default: return d;
      endcase
   endfunction

   // Model: results queue in transfer order; the head is visible once it has aged one edge,
   // and a new transfer fits while fewer than two are held or the head leaves this cycle.
   always @(negedge clk) begin : model
      logic [3:0] expReady;
      logic       expValid;
      bit         canAccept;
      int         win;
      int         cand;
      expValid  = (mQueue.size() > 0) && (mQueue[0].age >= 1);
      canAccept = (mQueue.size() < 2) || (expValid && outReady);
      expReady  = '0;
      win       = -1;
      if (!rst && canAccept) begin
         for (int k = 1; k <= NREQ; k++) begin
            cand = (mLast + k) % NREQ;
            if (win < 0 && reqValid[cand]) win = cand;
         end
      end
      if (win >= 0) expReady[win] = 1'b1;

      if (mArmed) begin
         checkOutput("model_req_ready", 32'(reqReady), 32'(expReady));
         checkOutput("model_out_valid", 32'(outValid), 32'(expValid));
         checkOutput("model_in_flight", 32'(inFlight), mQueue.size());
         if (expValid) begin
            checkOutput("model_out_data", 32'(outData), 32'(mQueue[0].data));
            checkOutput("model_out_id", 32'(outId), mQueue[0].id);
         end
      end

      if (rst) begin
         mQueue.delete();
         mLast  = NREQ - 1;
         mArmed = 1'b1;
      end else begin
         if (expValid && outReady) void'(mQueue.pop_front());
         for (int k = 0; k < mQueue.size(); k++) mQueue[k].age = mQueue[k].age + 1;
         if (win >= 0) begin
            mQueue.push_back('{modelOp(reqData[win*16 +: 16], reqOp[2*win +: 2]), win, 0});
            mLast = win;
         end
      end
   end

   initial begin
      rst       = 1'b1;
      sValid    = '0;
      sOp       = '0;
      sData     = '0;
      sOutReady = 1'b1;
      applyStimulus(4'hF, 8'h00, 64'h0, 1'b1);

      // Reset state, with every requester valid so req_ready must still be forced low.
      nextCycle();
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(reqReady), 32'h0);
      checkOutput("rst_out_valid", 32'(outValid), 32'h0);
      checkOutput("rst_in_flight", 32'(inFlight), 32'h0);
      checkOutput("rst_out_data", 32'(outData), 32'h0);
      checkOutput("rst_out_id", 32'(outId), 32'h0);
      nextCycle();

      // HALF abs of 0xC000, issued in the first cycle out of reset.
      rst = 1'b0;
      applyStimulus(4'b0001, 8'b0000_0001, 64'h0000_0000_0000_C000, 1'b1);
      @(negedge clk);
      checkOutput("half_first_grant", 32'(reqReady), 32'h1);
      nextCycle();
      applyStimulus(4'b0000, 8'h00, 64'h0, 1'b1);
      @(negedge clk);
      checkOutput("half_lat1_valid", 32'(outValid), 32'h0);
      checkOutput("half_lat1_inflight", 32'(inFlight), 32'h1);
      nextCycle();
      @(negedge clk);
      checkOutput("half_lat2_valid", 32'(outValid), 32'h1);
      checkOutput("half_abs_data", 32'(outData), 32'h4000);
      checkOutput("half_abs_id", 32'(outId), 32'h0);
      nextCycle();
      @(negedge clk);
      checkOutput("half_drained", 32'(inFlight), 32'h0);
      nextCycle();

      // Round-robin over four continuously valid requesters, negating +0.
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      applyStimulus(4'hF, 8'hAA, 64'h0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i < 6) checkOutput("rr_grant", 32'(reqReady), 32'(1) << (i % 4));
         if (i >= 2) begin
            checkOutput("rr_valid", 32'(outValid), 32'h1);
            checkOutput("rr_data", 32'(outData), 32'h8000);
            checkOutput("rr_id", 32'(outId), (i - 2) % 4);
         end
         nextCycle();
      end
      applyStimulus(4'h0, 8'h00, 64'h0, 1'b1);
      repeat (3) nextCycle();

      // Stall: out_ready low for four cycles with everybody valid.
      applyStimulus(4'hF, 8'b11_10_01_00, 64'h845A_835A_825A_815A, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            checkOutput("stall_grant0", 32'(reqReady), 32'h1);
            checkOutput("stall_empty", 32'(outValid), 32'h0);
         end else if (i == 1) begin
            checkOutput("stall_grant1", 32'(reqReady), 32'h2);
         end else begin
            checkOutput("stall_ready_low", 32'(reqReady), 32'h0);
            checkOutput("stall_full", 32'(inFlight), 32'h2);
            checkOutput("stall_hold_data", 32'(outData), 32'h815A);
            checkOutput("stall_hold_id", 32'(outId), 32'h0);
         end
         nextCycle();
      end
      outReady = 1'b1;
      @(negedge clk);
      checkOutput("release_grant", 32'(reqReady), 32'h4);
      checkOutput("release_inflight", 32'(inFlight), 32'h2);
      nextCycle();
      @(negedge clk);
      checkOutput("overlap_inflight", 32'(inFlight), 32'h2);
      checkOutput("overlap_no_bubble", 32'(outValid), 32'h1);
      checkOutput("overlap_data", 32'(outData), 32'h025A);
      checkOutput("overlap_id", 32'(outId), 32'h1);
      nextCycle();
      repeat (2) nextCycle();
      applyStimulus(4'h0, 8'h00, 64'h0, 1'b1);
      repeat (3) nextCycle();

      // Reset pulse with two results in flight.
      applyStimulus(4'b0100, 8'b0011_0000, 64'h0000_1234_0000_0000, 1'b0);
      repeat (2) nextCycle();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_ready", 32'(reqReady), 32'h0);
      checkOutput("midrst_before", 32'(inFlight), 32'h2);
      nextCycle();
      rst = 1'b0;
      applyStimulus(4'hF, 8'h00, 64'h1111_2222_3333_4444, 1'b1);
      @(negedge clk);
      checkOutput("midrst_out_valid", 32'(outValid), 32'h0);
      checkOutput("midrst_in_flight", 32'(inFlight), 32'h0);
      checkOutput("midrst_grant0", 32'(reqReady), 32'h1);
      nextCycle();
      repeat (2) nextCycle();
      applyStimulus(4'h0, 8'h00, 64'h0, 1'b1);
      repeat (3) nextCycle();

      // SINGLE: nabs of +1.0, then abs of a negative quiet NaN.
      sValid = 2'b11;
      sOp    = 4'b01_11;
      sData  = {32'hFFC0_0000, 32'h3F80_0000};
      @(negedge clk);
      checkOutput("single_grant0", 32'(sReady), 32'h1);
      nextCycle();
      @(negedge clk);
      checkOutput("single_grant1", 32'(sReady), 32'h2);
      nextCycle();
      sValid = 2'b00;
      @(negedge clk);
      checkOutput("single_nabs_valid", 32'(sOutValid), 32'h1);
      checkOutput("single_nabs_data", sOutData, 32'hBF80_0000);
      checkOutput("single_nabs_id", 32'(sOutId), 32'h0);
      nextCycle();
      @(negedge clk);
      checkOutput("single_nan_data", sOutData, 32'h7FC0_0000);
      checkOutput("single_nan_id", 32'(sOutId), 32'h1);
      nextCycle();
      repeat (2) nextCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
